param_mem: RTL and testbench

PARAM_MEM -- requirements
Module: param_mem

---
 rtl/param_mem_pkg.sv | 27 ++
 rtl/param_mem_lane_merge.sv | 28 ++
 rtl/param_mem.sv | 187 ++++++++++++++++++
 tb/tb_param_mem.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_mem_pkg.sv
// -----------------------------------------------------------------------------
// param_mem_pkg
// Shared definitions for the parameterised single-clock memory:
//   - mem_state_e : sweep/serve FSM states (CLEAR, IDLE)
//   - RD_OLD/RD_NEW : read-during-write behaviour selectors for RD_MODE
//   - addr_width() : address width derivation, never narrower than one bit
// -----------------------------------------------------------------------------
package param_mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } mem_state_e;

    localparam int RD_OLD = 32'd0;
    localparam int RD_NEW = 32'd1;

    // A two-word array still needs one address bit, so clamp at 1.
    function automatic int addr_width(input int depth);
        if (depth <= 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(depth);
        end
    endfunction

endpackage

// File: rtl/param_mem_lane_merge.sv
// -----------------------------------------------------------------------------
// mem_lane_merge
// Combines an old and a new data word lane by lane: lanes whose mask bit is set
// take the new word, all other lanes keep the old word.
// Ports:
//   i_old    [DATA_W-1:0] current stored word
//   i_new    [DATA_W-1:0] incoming write data
//   i_mask   [LANES-1:0]  per-lane select (1 = take new)
//   o_merged [DATA_W-1:0] resulting word
// -----------------------------------------------------------------------------
module mem_lane_merge #(
    parameter int DATA_W = 8,
    parameter int LANES  = 1
) (
    input  logic [DATA_W-1:0] i_old,
    input  logic [DATA_W-1:0] i_new,
    input  logic [LANES-1:0]  i_mask,
    output logic [DATA_W-1:0] o_merged
);

    localparam int LANE_W = DATA_W / LANES;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign o_merged[l*LANE_W +: LANE_W] = i_mask[l] ? i_new[l*LANE_W +: LANE_W]
                                                        : i_old[l*LANE_W +: LANE_W];
    end

endmodule

// File: rtl/param_mem.sv
// -----------------------------------------------------------------------------
// param_mem
// Single-clock, one-write/one-read memory with per-lane write mask, selectable
// read-during-write behaviour and a self-clearing sweep after reset or on
// request.
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset; starts a full clear sweep
//   write_en     write request            write_addr [ADDR_W-1:0]
//   write_data   [DATA_W-1:0]             write_mask [LANES-1:0]
//   read_en      read request             read_addr  [ADDR_W-1:0]
//   read_data    [DATA_W-1:0] registered read data (held between reads)
//   read_valid   read_data answers the read accepted in the previous cycle
//   clear_req    request a zeroing sweep of the whole array
//   busy         sweep in progress; all requests ignored
//   addr_err     one-cycle pulse for an accepted access with address >= DEPTH
// -----------------------------------------------------------------------------
module param_mem
    import param_mem_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 16,
    parameter  int LANES   = 1,
    parameter  int RD_MODE = 0,
    localparam int ADDR_W  = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [LANES-1:0]  write_mask,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    input  logic              clear_req,
    output logic              busy,
    output logic              addr_err
);

    // One extra bit so the range test also works when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

    // Storage has no reset so it can map onto block RAM; the sweep zeroes it.
    logic [DATA_W-1:0] r_mem [DEPTH];

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [DATA_W-1:0] r_read_data;
    logic              r_read_valid;
    logic              r_addr_err;
    logic              w_busy;

    logic              w_idle;
    logic              w_wr_oor;
    logic              w_rd_oor;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [ADDR_W-1:0] w_rd_idx;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_err;

    assign w_idle   = (r_state == IDLE);
    assign w_wr_oor = ({1'b0, write_addr} >= DEPTH_EXT);
    assign w_rd_oor = ({1'b0, read_addr}  >= DEPTH_EXT);
    assign w_wr_acc = w_idle & write_en & ~w_wr_oor;
    assign w_rd_acc = w_idle & read_en;
    // Out-of-range addresses are steered to word 0 so no array access leaves bounds.
    assign w_wr_idx = w_wr_oor ? '0 : write_addr;
    assign w_rd_idx = w_rd_oor ? '0 : read_addr;
    assign w_err    = w_idle & ((write_en & w_wr_oor) | (read_en & w_rd_oor));

    // The same merged word feeds the array write and the write-first bypass.
    mem_lane_merge #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_merge (
        .i_old    (r_mem[w_wr_idx]),
        .i_new    (write_data),
        .i_mask   (write_mask),
        .o_merged (w_merged)
    );

    // Read word selection: zero when out of range, bypass on write-first collision.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_oor) begin
            w_rd_word = '0;
        end else if ((RD_MODE == RD_NEW) && w_wr_acc && (write_addr == read_addr)) begin
            w_rd_word = w_merged;
        end else begin
            w_rd_word = r_mem[w_rd_idx];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; clear_req only matters when idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR: begin
                if (r_clr_cnt == CLR_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = CLEAR;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // FSM output decode.
    always_comb begin
        w_busy = 1'b1;
        case (r_state)
            CLEAR:   w_busy = 1'b1;
            IDLE:    w_busy = 1'b0;
            default: w_busy = 1'b1;
        endcase
    end

    assign busy = w_busy;

    // Sweep address counter; parked at 0 while idle so every sweep starts at word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR) begin
            if (r_clr_cnt == CLR_LAST) begin
                r_clr_cnt <= '0;
            end else begin
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            end
        end else begin
            r_clr_cnt <= '0;
        end
    end

    // Array write port: sweep zeroes one word per cycle, otherwise masked write.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc) begin
            r_mem[w_wr_idx] <= w_merged;
        end
    end

    // Registered read response and address-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_read_valid <= w_rd_acc;
            r_addr_err   <= w_err;
            if (w_rd_acc) begin
                r_read_data <= w_rd_word;
            end
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_param_mem.sv
// -----------------------------------------------------------------------------
// tb_param_mem
// Three instances share one stimulus stream:
//   0: DATA_W=8,  DEPTH=16, LANES=1, RD_MODE=0
//   1: DATA_W=16, DEPTH=12, LANES=2, RD_MODE=0
//   2: DATA_W=16, DEPTH=12, LANES=2, RD_MODE=1
// Each is compared every cycle against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_param_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  wm;
    logic        re;
    logic [3:0]  ra;
    logic        cr;

    logic [7:0]  rd_a;
    logic [15:0] rd_b;
    logic [15:0] rd_c;
    logic [2:0]  v_o;
    logic [2:0]  busy_o;
    logic [2:0]  err_o;
    logic [15:0] rd_o [3];

    always #5 clk = ~clk;

    assign rd_o[0] = {8'h00, rd_a};
    assign rd_o[1] = rd_b;
    assign rd_o[2] = rd_c;

    param_mem #(.DATA_W(8), .DEPTH(16), .LANES(1), .RD_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .write_en(we), .write_addr(wa), .write_data(wd[7:0]), .write_mask(wm[0:0]),
        .read_en(re), .read_addr(ra), .read_data(rd_a), .read_valid(v_o[0]),
        .clear_req(cr), .busy(busy_o[0]), .addr_err(err_o[0]));

    param_mem #(.DATA_W(16), .DEPTH(12), .LANES(2), .RD_MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .write_en(we), .write_addr(wa), .write_data(wd), .write_mask(wm),
        .read_en(re), .read_addr(ra), .read_data(rd_b), .read_valid(v_o[1]),
        .clear_req(cr), .busy(busy_o[1]), .addr_err(err_o[1]));

    param_mem #(.DATA_W(16), .DEPTH(12), .LANES(2), .RD_MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .write_en(we), .write_addr(wa), .write_data(wd), .write_mask(wm),
        .read_en(re), .read_addr(ra), .read_data(rd_c), .read_valid(v_o[2]),
        .clear_req(cr), .busy(busy_o[2]), .addr_err(err_o[2]));

    int checks = 0;
    int errors = 0;

    // Single comparison point: counts and reports.
    task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_depth [3] = '{16, 12, 12};
    int          m_dw    [3] = '{8, 16, 16};
    int          m_lanes [3] = '{1, 2, 2};
    int          m_mode  [3] = '{0, 0, 1};
    logic [15:0] m_mem   [3][16];
    int          m_clr   [3];
    logic [15:0] m_rd    [3];
    logic        m_v     [3];
    logic        m_err   [3];

    function automatic logic [15:0] m_merge(input int k, input logic [15:0] old_w,
                                            input logic [15:0] new_w, input logic [1:0] msk);
        logic [15:0] r;
        int lw;
        r  = old_w;
        lw = m_dw[k] / m_lanes[k];
        for (int b = 0; b < m_dw[k]; b++) begin
            if (msk[b / lw]) r[b] = new_w[b];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_clr[k] = m_depth[k];
            m_rd[k]  = 16'h0000;
            m_v[k]   = 1'b0;
            m_err[k] = 1'b0;
            for (int a = 0; a < 16; a++) m_mem[k][a] = 16'($urandom);
        end
    endtask

    task automatic model_edge();
        logic wr_ok;
        logic rd_ok;
        logic [15:0] nw;
        for (int k = 0; k < 3; k++) begin
            if (m_clr[k] > 0) begin
                m_mem[k][m_depth[k] - m_clr[k]] = 16'h0000;
                m_clr[k]--;
                m_v[k]   = 1'b0;
                m_err[k] = 1'b0;
            end else begin
                wr_ok = we && (int'(wa) < m_depth[k]);
                rd_ok = re && (int'(ra) < m_depth[k]);
                nw    = wr_ok ? m_merge(k, m_mem[k][wa], wd, wm) : 16'h0000;
                m_err[k] = (we && !wr_ok) || (re && !rd_ok);
                m_v[k]   = re;
                if (re) begin
                    if (!rd_ok)                                   m_rd[k] = 16'h0000;
                    else if (m_mode[k] == 1 && wr_ok && wa == ra) m_rd[k] = nw;
                    else                                          m_rd[k] = m_mem[k][ra];
                end
                if (wr_ok) m_mem[k][wa] = nw;
                if (cr)    m_clr[k] = m_depth[k];
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk_eq($sformatf("%s_busy%0d", tag, k), 16'(busy_o[k]), 16'(m_clr[k] > 0));
            chk_eq($sformatf("%s_valid%0d", tag, k), 16'(v_o[k]), 16'(m_v[k]));
            chk_eq($sformatf("%s_err%0d", tag, k), 16'(err_o[k]), 16'(m_err[k]));
            chk_eq($sformatf("%s_data%0d", tag, k), rd_o[k], m_rd[k]);
        end
    endtask

    // One clock: model follows the rising edge, outputs checked on the falling edge.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle_inputs();
        we = 1'b0; wa = 4'd0; wd = 16'h0000; wm = 2'b00;
        re = 1'b0; ra = 4'd0; cr = 1'b0;
    endtask

    task automatic measure_sweep(input string tag, input int exp_a, input int exp_b);
        int na;
        int nb;
        na = 0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy_o[0]) na++;
            if (busy_o[1]) nb++;
            cycle(tag);
        end
        chk_eq({tag, "_len_a"}, 16'(na), 16'(exp_a));
        chk_eq({tag, "_len_b"}, 16'(nb), 16'(exp_b));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_n;
        idle_inputs();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Power-up sweep length, then every word reads zero.
        measure_sweep("sweep0", 16, 12);
        for (int a = 0; a < 16; a++) begin
            re = 1'b1; ra = 4'(a);
            cycle("rd_init");
            chk_eq("rd_init_zero", {8'h00, rd_a}, 16'h0000);
        end
        idle_inputs();
        cycle("idle");

        // Single-lane write then read, data held after the response.
        we = 1'b1; wa = 4'd3; wd = 16'h00A5; wm = 2'b01;
        cycle("wr3");
        we = 1'b0; re = 1'b1; ra = 4'd3;
        cycle("rd3");
        chk_eq("rd3_data", {8'h00, rd_a}, 16'h00A5);
        chk_eq("rd3_valid", 16'(v_o[0]), 16'h0001);
        re = 1'b0;
        cycle("rd3_hold");
        chk_eq("rd3_hold_valid", 16'(v_o[0]), 16'h0000);
        chk_eq("rd3_hold_data", {8'h00, rd_a}, 16'h00A5);

        // Masked collision: read-old vs write-first.
        we = 1'b1; wa = 4'd5; wd = 16'h1234; wm = 2'b11;
        cycle("wr5");
        wd = 16'hABCD; wm = 2'b10; re = 1'b1; ra = 4'd5;
        cycle("coll5");
        chk_eq("coll5_old", rd_b, 16'h1234);
        chk_eq("coll5_new", rd_c, 16'hAB34);
        we = 1'b0;
        cycle("rd5");
        chk_eq("rd5_b", rd_b, 16'hAB34);
        chk_eq("rd5_c", rd_c, 16'hAB34);
        idle_inputs();

        // Out-of-range write and read on the DEPTH=12 instances.
        we = 1'b1; wa = 4'd13; wd = 16'h00FF; wm = 2'b11;
        cycle("wr13");
        chk_eq("wr13_err", 16'(err_o[1]), 16'h0001);
        we = 1'b0; re = 1'b1; ra = 4'd13;
        cycle("rd13");
        chk_eq("rd13_err", 16'(err_o[1]), 16'h0001);
        chk_eq("rd13_data", rd_b, 16'h0000);
        chk_eq("rd13_valid", 16'(v_o[1]), 16'h0001);
        re = 1'b0;
        cycle("rd13_after");
        chk_eq("rd13_err_drop", 16'(err_o[1]), 16'h0000);

        // Randomised traffic, collisions biased up, occasional clear requests.
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            wa = 4'($urandom_range(0, 15));
            wd = 16'($urandom);
            wm = 2'($urandom_range(0, 3));
            re = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
            cr = ($urandom_range(0, 39) == 0);
            cycle("rand");
        end
        idle_inputs();
        wait_n = 0;
        while ((busy_o != 3'b000) && (wait_n < 40)) begin
            cycle("drain");
            wait_n++;
        end
        chk_eq("drain_timeout", 16'(busy_o), 16'h0000);

        // Clear request, reset mid-sweep, full sweep after release.
        we = 1'b1; wa = 4'd7; wd = 16'h0055; wm = 2'b11;
        cycle("wr7");
        we = 1'b0; cr = 1'b1;
        cycle("clr");
        cr = 1'b0;
        repeat (3) cycle("sweep");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_mid");
        chk_eq("rst_mid_busy", 16'(busy_o[0]), 16'h0001);
        cycle("rst_low");
        rst_n = 1'b1;
        measure_sweep("sweep1", 16, 12);
        re = 1'b1; ra = 4'd7;
        cycle("rd7");
        chk_eq("rd7_a", {8'h00, rd_a}, 16'h0000);
        chk_eq("rd7_b", rd_b, 16'h0000);
        idle_inputs();
        cycle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
